// File: rtl/call_frame_stack_pkg.sv
// Shared types for the call-frame stack: value type codes, trap codes and the frame payload.
package call_frame_stack_pkg;

  localparam int unsigned ROM_ADDR    = 6;
  localparam int unsigned STACK_DEPTH = 7;
  localparam int unsigned BASE_W      = STACK_DEPTH + 1;

  typedef enum logic [1:0] {
    TYPE_I32 = 2'd0,
    TYPE_I64 = 2'd1,
    TYPE_F32 = 2'd2,
    TYPE_F64 = 2'd3
  } val_type_e;

  typedef enum logic [3:0] {
    TRAP_NONE           = 4'h0,
    TRAP_CALL_OVERFLOW  = 4'h5,
    TRAP_CALL_UNDERFLOW = 4'h6
  } trap_e;

  typedef struct packed {
    logic [ROM_ADDR-1:0] pc;
    logic [BASE_W-1:0]   base;
    logic                arity;
    val_type_e           vtype;
  } frame_t;

endpackage

// File: rtl/call_frame_stack_if.sv
// Call/return request and top-of-stack status bundle between the CPU core and the frame stack.
interface call_frame_stack_if
  import call_frame_stack_pkg::*;
#(
  parameter int unsigned CALL_DEPTH = 4
);

  logic                  push;
  logic                  pop;
  logic [ROM_ADDR-1:0]   push_pc;
  logic [BASE_W-1:0]     push_base;
  logic                  push_arity;
  logic [1:0]            push_type;
  logic [ROM_ADDR-1:0]   top_pc;
  logic [BASE_W-1:0]     top_base;
  logic                  top_arity;
  logic [1:0]            top_type;
  logic [CALL_DEPTH:0]   depth;
  logic                  empty;
  logic                  full;
  logic [3:0]            trap;

  modport master (
    output push, pop, push_pc, push_base, push_arity, push_type,
    input  top_pc, top_base, top_arity, top_type, depth, empty, full, trap
  );

  modport slave (
    input  push, pop, push_pc, push_base, push_arity, push_type,
    output top_pc, top_base, top_arity, top_type, depth, empty, full, trap
  );

endinterface

// File: rtl/call_frame_stack_frame_ram.sv
// Frame storage: synchronous write, asynchronous read, no reset.
module call_frame_stack_frame_ram
  import call_frame_stack_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  frame_t           wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output frame_t           rd_data_c
);

  localparam int unsigned N_ENTRIES = 1 << IDX_W;

  frame_t mem [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/call_frame_stack.sv
// Hardware call-frame stack: push saves a frame on call, pop restores on return,
// push+pop replaces the top frame for tail calls. Overflow/underflow raise a sticky trap.
module call_frame_stack
  import call_frame_stack_pkg::*;
#(
  parameter int unsigned CALL_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  call_frame_stack_if.slave   bus
);

  localparam int unsigned CNT_W     = CALL_DEPTH + 1;
  localparam int unsigned N_FRAMES  = 1 << CALL_DEPTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_FRAMES);

  logic [CNT_W-1:0]      depth_q, depth_d;
  trap_e                 trap_q, trap_d;
  frame_t                top_q, top_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  wr_en;
  logic [CALL_DEPTH-1:0] wr_idx;
  logic [CALL_DEPTH-1:0] rd_idx;
  frame_t                rd_frame;
  frame_t                in_frame;

  assign in_frame = '{pc:    bus.push_pc,
                      base:  bus.push_base,
                      arity: bus.push_arity,
                      vtype: val_type_e'(bus.push_type)};

  // Frame just below the top, restored on a plain return.
  assign rd_idx = CALL_DEPTH'(depth_q - CNT_W'(2));

  call_frame_stack_frame_ram #(.IDX_W(CALL_DEPTH)) u_frame_ram (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (in_frame),
    .rd_idx    (rd_idx),
    .rd_data_c (rd_frame)
  );

  // Next-state decode; a pending trap freezes everything until reset.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = CALL_DEPTH'(depth_q);
    depth_d = depth_q;
    trap_d  = trap_q;
    top_d   = top_q;
    if (trap_q == TRAP_NONE) begin
      unique case ({bus.push, bus.pop})
        2'b10: begin
          if (full_q) begin
            trap_d = TRAP_CALL_OVERFLOW;
          end else begin
            wr_en   = 1'b1;
            depth_d = depth_q + CNT_W'(1);
            top_d   = in_frame;
          end
        end
        2'b01: begin
          if (empty_q) begin
            trap_d = TRAP_CALL_UNDERFLOW;
          end else if (depth_q == CNT_W'(1)) begin
            depth_d = '0;
            top_d   = '0;
          end else begin
            depth_d = depth_q - CNT_W'(1);
            top_d   = rd_frame;
          end
        end
        2'b11: begin
          if (empty_q) begin
            trap_d = TRAP_CALL_UNDERFLOW;
          end else begin
            wr_en  = 1'b1;
            wr_idx = CALL_DEPTH'(depth_q - CNT_W'(1));
            top_d  = in_frame;
          end
        end
        default: ;
      endcase
    end
    empty_d = (depth_d == '0);
    full_d  = (depth_d == FULL_CNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      trap_q  <= TRAP_NONE;
      top_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      depth_q <= depth_d;
      trap_q  <= trap_d;
      top_q   <= top_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign bus.top_pc    = top_q.pc;
  assign bus.top_base  = top_q.base;
  assign bus.top_arity = top_q.arity;
  assign bus.top_type  = top_q.vtype;
  assign bus.depth     = depth_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.trap      = trap_q;

endmodule

// File: tb/tb_call_frame_stack.sv
// Directed testbench for call_frame_stack with a 4-frame configuration.
module tb_call_frame_stack;

  localparam int unsigned CD = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  call_frame_stack_if #(.CALL_DEPTH(CD)) bus ();

  call_frame_stack #(.CALL_DEPTH(CD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operation for exactly one rising edge; returns at the following falling edge.
  task automatic op(input logic p, input logic q, input int pc, input int base,
                    input logic ar, input int ty);
    @(negedge clk);
    bus.push       = p;
    bus.pop        = q;
    bus.push_pc    = 6'(pc);
    bus.push_base  = 8'(base);
    bus.push_arity = ar;
    bus.push_type  = 2'(ty);
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0;
    bus.push_pc = '0; bus.push_base = '0; bus.push_arity = 1'b0; bus.push_type = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset state after idling
    repeat (3) @(negedge clk);
    check("rst_depth", 32'(bus.depth), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full",  32'(bus.full), 0);
    check("rst_trap",  32'(bus.trap), 0);
    check("rst_top_pc", 32'(bus.top_pc), 0);

    // 2: two calls then a return
    op(1, 0, 33, 5, 1, 1);
    check("push1_pc", 32'(bus.top_pc), 33);
    check("push1_depth", 32'(bus.depth), 1);
    op(1, 0, 40, 9, 0, 0);
    check("push2_pc", 32'(bus.top_pc), 40);
    check("push2_base", 32'(bus.top_base), 9);
    check("push2_depth", 32'(bus.depth), 2);
    op(0, 1, 0, 0, 0, 0);
    check("pop_pc", 32'(bus.top_pc), 33);
    check("pop_base", 32'(bus.top_base), 5);
    check("pop_type", 32'(bus.top_type), 1);
    check("pop_arity", 32'(bus.top_arity), 1);
    check("pop_depth", 32'(bus.depth), 1);

    // 4: tail call at depth 2 then return
    op(1, 0, 20, 7, 0, 2);
    check("d2_depth", 32'(bus.depth), 2);
    op(1, 1, 12, 3, 0, 3);
    check("tail_depth", 32'(bus.depth), 2);
    check("tail_pc", 32'(bus.top_pc), 12);
    check("tail_type", 32'(bus.top_type), 3);
    op(0, 1, 0, 0, 0, 0);
    check("tail_ret_pc", 32'(bus.top_pc), 33);
    check("tail_ret_depth", 32'(bus.depth), 1);

    // 3: fill, tail call when full, overflow, frozen pops
    op(1, 0, 50, 1, 0, 0);
    op(1, 0, 51, 2, 0, 0);
    check("fill3_full", 32'(bus.full), 0);
    op(1, 0, 52, 4, 1, 2);
    check("full_flag", 32'(bus.full), 1);
    check("full_empty", 32'(bus.empty), 0);
    check("full_depth", 32'(bus.depth), 4);
    check("full_pc", 32'(bus.top_pc), 52);
    op(1, 1, 60, 6, 0, 1);
    check("full_tail_trap", 32'(bus.trap), 0);
    check("full_tail_depth", 32'(bus.depth), 4);
    check("full_tail_pc", 32'(bus.top_pc), 60);
    op(1, 0, 61, 8, 1, 3);
    check("ovf_trap", 32'(bus.trap), 5);
    check("ovf_depth", 32'(bus.depth), 4);
    check("ovf_pc", 32'(bus.top_pc), 60);
    check("ovf_base", 32'(bus.top_base), 6);
    op(0, 1, 0, 0, 0, 0);
    op(0, 1, 0, 0, 0, 0);
    check("frozen_depth", 32'(bus.depth), 4);
    check("frozen_pc", 32'(bus.top_pc), 60);
    check("frozen_trap", 32'(bus.trap), 5);

    // 6a: async reset between edges while trapped and full
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_trap", 32'(bus.trap), 0);
    check("async_full_depth", 32'(bus.depth), 0);
    @(negedge clk);
    reset = 1'b0;

    // 5: underflow by pop, then by push+pop
    op(0, 1, 0, 0, 0, 0);
    check("unf_pop_trap", 32'(bus.trap), 6);
    check("unf_pop_depth", 32'(bus.depth), 0);
    check("unf_pop_empty", 32'(bus.empty), 1);
    do_reset();
    check("rst2_trap", 32'(bus.trap), 0);
    op(1, 1, 44, 2, 1, 1);
    check("unf_tail_trap", 32'(bus.trap), 6);
    check("unf_tail_depth", 32'(bus.depth), 0);
    check("unf_tail_pc", 32'(bus.top_pc), 0);
    do_reset();

    // 6b: async reset at depth 3, sampled before the next rising edge
    op(1, 0, 10, 1, 0, 0);
    op(1, 0, 11, 2, 0, 0);
    op(1, 0, 13, 3, 1, 2);
    check("d3_depth", 32'(bus.depth), 3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_depth", 32'(bus.depth), 0);
    check("async_empty", 32'(bus.empty), 1);
    check("async_top_pc", 32'(bus.top_pc), 0);
    check("async_top_base", 32'(bus.top_base), 0);
    @(negedge clk);
    reset = 1'b0;

    // Pop to depth 1 then 0 after fresh pushes
    op(1, 0, 21, 4, 0, 1);
    op(1, 0, 22, 5, 1, 0);
    op(0, 1, 0, 0, 0, 0);
    check("post_pop_pc", 32'(bus.top_pc), 21);
    check("post_pop_base", 32'(bus.top_base), 4);
    op(0, 1, 0, 0, 0, 0);
    check("last_pop_depth", 32'(bus.depth), 0);
    check("last_pop_empty", 32'(bus.empty), 1);
    check("last_pop_pc", 32'(bus.top_pc), 0);
    check("last_pop_trap", 32'(bus.trap), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
